// File: rtl/fir_coeff_loader_pkg.sv
// Shared definitions for the FIR coefficient loader: state encoding and the
// default sizes that must agree with the filter datapath.
package fir_coeff_loader_pkg;

  localparam int DEF_NUM_TAPS   = 8;
  localparam int DEF_COEFF_BITS = 8;
  localparam int DEF_ADDR_BITS  = 4;

  // Encoding 2'd3 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Host configuration port of the FIR coefficient loader.
interface fir_coeff_loader_if #(
  parameter int ADDR_BITS  = 4,
  parameter int COEFF_BITS = 8
);
  // A transfer (write, optionally with commit) happens on a rising clock edge
  // where cfg_valid & cfg_ready; the host holds valid/addr/data/commit until then.
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [ADDR_BITS-1:0]  cfg_addr;
  logic [COEFF_BITS-1:0] cfg_data;
  logic                  cfg_commit;
  logic                  cfg_abort;
  logic                  cfg_err;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit, cfg_abort,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit, cfg_abort,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/fir_coeff_loader_tick_counter.sv
// Loadable down-counter that only advances on the sample tick; saturates at zero.
module fir_coeff_loader_tick_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/fir_coeff_loader.sv
// Shadow-bank coefficient loader: host writes fill a shadow bank, a commit arms
// a swap that lands on the next sample tick, then the filter is flushed for NUM_TAPS ticks.
module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
#(
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int COEFF_BITS = DEF_COEFF_BITS,
  parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           sample_tick,
  fir_coeff_loader_if.slave              cfg,
  output logic [NUM_TAPS*COEFF_BITS-1:0] coeff_out,
  output logic                           filter_flush,
  output logic                           coeff_update,
  output logic                           busy,
  output state_t                         state_dbg
);
  localparam int BANK_BITS = NUM_TAPS * COEFF_BITS;
  localparam int CNT_BITS  = $clog2(NUM_TAPS + 1);
  localparam logic [CNT_BITS-1:0]  FLUSH_LEN    = CNT_BITS'(NUM_TAPS);
  localparam logic [CNT_BITS-1:0]  CNT_ONE      = CNT_BITS'(1);
  localparam logic [ADDR_BITS:0]   TAP_LIMIT    = (ADDR_BITS + 1)'(NUM_TAPS);
  localparam logic [BANK_BITS-1:0] DEFAULT_BANK = {{(BANK_BITS - 1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [BANK_BITS-1:0]  shadow_q, shadow_d;
  logic [BANK_BITS-1:0]  active_q, active_d;
  logic [NUM_TAPS-1:0]   mask_q, mask_d;
  logic                  flush_q, flush_d;
  logic                  update_q, update_d;
  logic                  err_q, err_d;

  logic                  xfer;
  logic                  addr_ok;
  logic [NUM_TAPS-1:0]   mask_wr;
  logic                  cnt_load;
  logic [CNT_BITS-1:0]   flush_cnt;
  logic                  cnt_zero;

  assign xfer    = cfg.cfg_valid && cfg.cfg_ready;
  assign addr_ok = ({1'b0, cfg.cfg_addr} < TAP_LIMIT);

  always_comb begin
    mask_wr = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      mask_wr[k] = ({1'b0, cfg.cfg_addr} == (ADDR_BITS + 1)'(k));
    end
  end

  fir_coeff_loader_tick_counter #(.W(CNT_BITS)) u_flush_cnt (
    .clock    (clock),
    .reset    (reset),
    .tick     (sample_tick),
    .load     (cnt_load),
    .load_val (FLUSH_LEN),
    .count    (flush_cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    mask_d   = mask_q;
    flush_d  = flush_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          // A bad address drops the whole transfer, commit included.
          if (!addr_ok) begin
            err_d = 1'b1;
          end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
              if (mask_wr[k]) shadow_d[k*COEFF_BITS +: COEFF_BITS] = cfg.cfg_data;
            end
            mask_d = mask_q | mask_wr;
            if (cfg.cfg_commit) begin
              if (&mask_d) state_d = S_ARMED;
              else         err_d   = 1'b1;
            end
          end
        end
      end
      S_ARMED: begin
        // The tick beats a same-cycle abort.
        if (sample_tick) begin
          active_d = shadow_q;
          update_d = 1'b1;
          cnt_load = 1'b1;
          mask_d   = '0;
          flush_d  = 1'b1;
          state_d  = S_FLUSH;
        end else if (cfg.cfg_abort) begin
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (cnt_zero || (sample_tick && (flush_cnt == CNT_ONE))) begin
          flush_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        flush_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      active_q <= DEFAULT_BANK;
      mask_q   <= '0;
      flush_q  <= 1'b0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      mask_q   <= mask_d;
      flush_q  <= flush_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  assign cfg.cfg_ready = (state_q == S_IDLE);
  assign cfg.cfg_err   = err_q;
  assign coeff_out     = active_q;
  assign filter_flush  = flush_q;
  assign coeff_update  = update_q;
  assign busy          = (state_q == S_ARMED) || (state_q == S_FLUSH);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader: vector table for host writes plus
// hand sequences for swap, abort, flush length, pending writes and async reset.
`timescale 1ns/1ps
module tb_fir_coeff_loader;
  import fir_coeff_loader_pkg::*;

  localparam int NT = 8;
  localparam int CB = 8;
  localparam int AB = 4;
  localparam logic [63:0] DEF_BANK = 64'h0000_0000_0000_0001;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic sample_tick = 1'b0;
  always #500 clock = ~clock;

  logic [NT*CB-1:0] coeff_out;
  logic             filter_flush;
  logic             coeff_update;
  logic             busy;
  state_t           state_dbg;

  fir_coeff_loader_if #(.ADDR_BITS(AB), .COEFF_BITS(CB)) cif ();

  fir_coeff_loader #(.NUM_TAPS(NT), .COEFF_BITS(CB), .ADDR_BITS(AB)) dut (
    .clock        (clock),
    .reset        (rst_n),
    .sample_tick  (sample_tick),
    .cfg          (cif),
    .coeff_out    (coeff_out),
    .filter_flush (filter_flush),
    .coeff_update (coeff_update),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- model / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int upd_seen = 0;
  int upd_exp  = 0;
  logic [7:0]  sh[NT];
  logic [63:0] active_m;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_shadow();
    logic [63:0] b;
    b = '0;
    for (int k = 0; k < NT; k++) b[k*8 +: 8] = sh[k];
    return b;
  endfunction

  task automatic expect_swap();
    exp_q.push_back(pack_shadow());
    upd_exp++;
  endtask

  // coeff_update must coincide with a queued swap and show that bank
  always @(negedge clock) begin
    if (rst_n && coeff_update) begin
      upd_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_update", 64'(coeff_update), 64'(0));
      end else begin
        active_m = exp_q.pop_front();
        check("swap_bank", 64'(coeff_out), active_m);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] a, input logic [7:0] d, input logic c);
    int waited;
    waited = 0;
    @(negedge clock);
    cif.cfg_valid  = 1'b1;
    cif.cfg_addr   = a;
    cif.cfg_data   = d;
    cif.cfg_commit = c;
    while (!cif.cfg_ready && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check("send_ready", 64'(cif.cfg_ready), 64'(1));
    if (cif.cfg_ready) begin
      @(posedge clock);
      #1;
      if (a < 4'(NT)) sh[a[2:0]] = d;
    end
    cif.cfg_valid  = 1'b0;
    cif.cfg_commit = 1'b0;
  endtask

  task automatic tick(input logic ab);
    @(negedge clock);
    sample_tick   = 1'b1;
    cif.cfg_abort = ab;
    @(posedge clock);
    #1;
    sample_tick   = 1'b0;
    cif.cfg_abort = 1'b0;
  endtask

  task automatic abort_only();
    @(negedge clock);
    cif.cfg_abort = 1'b1;
    @(posedge clock);
    #1;
    cif.cfg_abort = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       commit;
    logic       exp_err;
    logic       exp_ready;
  } vec_t;

  vec_t vecs[11];
  int   nflush;
  logic [7:0] pend_d;

  initial begin
    cif.cfg_valid  = 1'b0;
    cif.cfg_addr   = '0;
    cif.cfg_data   = '0;
    cif.cfg_commit = 1'b0;
    cif.cfg_abort  = 1'b0;
    for (int k = 0; k < NT; k++) sh[k] = 8'h00;
    active_m = DEF_BANK;

    for (int k = 0; k < 7; k++) vecs[k] = '{4'(k), 8'h10 + 8'(k), 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{4'd0,  8'h10, 1'b1, 1'b1, 1'b1};  // commit with tap7 missing
    vecs[8]  = '{4'd9,  8'h55, 1'b0, 1'b1, 1'b1};  // bad address
    vecs[9]  = '{4'd15, 8'h66, 1'b1, 1'b1, 1'b1};  // bad address + commit
    vecs[10] = '{4'd7,  8'h17, 1'b1, 1'b0, 1'b0};  // write completes bank and commits

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    check("rst_coeff",  64'(coeff_out), DEF_BANK);
    check("rst_ready",  64'(cif.cfg_ready), 64'(1));
    check("rst_busy",   64'(busy), 64'(0));
    check("rst_flush",  64'(filter_flush), 64'(0));
    check("rst_update", 64'(coeff_update), 64'(0));
    check("rst_err",    64'(cif.cfg_err), 64'(0));
    check("rst_state",  64'(state_dbg), 64'(S_IDLE));

    // table-driven writes / commits
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].addr, vecs[i].data, vecs[i].commit);
      @(negedge clock);
      check($sformatf("vec%0d_err", i),   64'(cif.cfg_err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_ready", i), 64'(cif.cfg_ready), 64'(vecs[i].exp_ready));
      check($sformatf("vec%0d_busy", i),  64'(busy), 64'(!vecs[i].exp_ready));
      check($sformatf("vec%0d_coeff", i), 64'(coeff_out), DEF_BANK);
    end

    // swap and flush length
    expect_swap();
    tick(1'b0);
    @(negedge clock);
    check("swap1_const", 64'(coeff_out), 64'h1716_1514_1312_1110);
    check("swap1_flush", 64'(filter_flush), 64'(1));
    check("swap1_ready", 64'(cif.cfg_ready), 64'(0));
    abort_only();
    @(negedge clock);
    check("flush_abort_ignored", 64'(filter_flush), 64'(1));
    nflush = 0;
    while (filter_flush && nflush < 20) begin
      tick(nflush[0]);
      @(negedge clock);
      nflush++;
    end
    check("flush_ticks", 64'(nflush), 64'(NT));
    check("post_flush_ready", 64'(cif.cfg_ready), 64'(1));
    check("post_flush_busy",  64'(busy), 64'(0));
    check("post_flush_update", 64'(coeff_update), 64'(0));

    // mask was cleared by the swap
    send(4'd2, sh[2], 1'b1);
    @(negedge clock);
    check("mask_cleared_err", 64'(cif.cfg_err), 64'(1));

    // arm, abort, re-commit without rewriting
    for (int k = 0; k < NT; k++) send(4'(k), 8'($urandom_range(0, 255)), (k == NT - 1));
    @(negedge clock);
    check("arm2_busy", 64'(busy), 64'(1));
    abort_only();
    @(negedge clock);
    check("abort_ready", 64'(cif.cfg_ready), 64'(1));
    check("abort_coeff", 64'(coeff_out), active_m);
    check("abort_no_update", 64'(upd_seen), 64'(upd_exp));
    send(4'd0, sh[0], 1'b1);
    @(negedge clock);
    check("recommit_err",  64'(cif.cfg_err), 64'(0));
    check("recommit_busy", 64'(busy), 64'(1));
    expect_swap();
    tick(1'b0);

    // host write presented during flush stays pending until IDLE
    pend_d = 8'($urandom_range(0, 255));
    fork
      begin
        repeat (NT) tick(1'b0);
      end
      begin
        send(4'd3, pend_d, 1'b0);
      end
    join
    @(negedge clock);
    check("pend_flush_done", 64'(filter_flush), 64'(0));
    for (int k = 0; k < NT; k++) begin
      if (k != 3) send(4'(k), 8'($urandom_range(0, 255)), (k == NT - 1));
    end
    @(negedge clock);
    check("arm3_busy", 64'(busy), 64'(1));

    // tick and abort together: swap wins
    expect_swap();
    tick(1'b1);
    @(negedge clock);
    check("tie_flush", 64'(filter_flush), 64'(1));
    check("tie_tap3",  64'(coeff_out[3*8 +: 8]), 64'(pend_d));

    // async reset mid-flush (flush_cnt = 5)
    repeat (3) tick(1'b0);
    @(negedge clock);
    check("pre_reset_flush", 64'(filter_flush), 64'(1));
    #200;
    rst_n = 1'b0;
    #1;
    check("async_rst_flush", 64'(filter_flush), 64'(0));
    check("async_rst_coeff", 64'(coeff_out), DEF_BANK);
    check("async_rst_ready", 64'(cif.cfg_ready), 64'(1));
    check("async_rst_busy",  64'(busy), 64'(0));
    @(negedge clock);
    rst_n = 1'b1;
    for (int k = 0; k < NT; k++) sh[k] = 8'h00;
    active_m = DEF_BANK;
    send(4'd5, 8'h42, 1'b1);
    @(negedge clock);
    check("post_rst_mask_err", 64'(cif.cfg_err), 64'(1));
    check("post_rst_coeff",    64'(coeff_out), DEF_BANK);

    repeat (2) @(negedge clock);
    check("exp_q_empty",  64'(exp_q.size()), 64'(0));
    check("update_count", 64'(upd_seen), 64'(upd_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
